bcm_plane_sequencer: RTL



---
 rtl/bcm_plane_sequencer.sv | 114 +++++++++++
 1 files changed

// File: rtl/bcm_plane_sequencer.sv
// Binary code modulation sequencer: scans the address range once per bit plane, then holds oe for a 2^plane weighted dwell.
// Build macro BCM_REVERSE_PLANE_EN selects descending plane order (PLANES-1 down to 0).
module bcm_plane_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 256,
  parameter int PLANES     = 8,
  parameter int PLANE_W    = 3,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [ADDR_W-1:0]     address,
  output logic [PLANE_W-1:0]    plane,
  output logic                  oe,
  output logic                  addr_wrap,
  output logic                  frame_done,
  output logic                  busy_dwell
);

  localparam int CNT_W = PRESCALE_W + PLANES;
  localparam logic [ADDR_W-1:0]  ADDR_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(PLANES - 1);
`ifdef BCM_REVERSE_PLANE_EN
  localparam logic [PLANE_W-1:0] PLANE_FIRST = PLANE_LAST;
`else
  localparam logic [PLANE_W-1:0] PLANE_FIRST = '0;
`endif

  typedef enum logic {SCAN = 1'b0, DWELL = 1'b1} state_t;

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  address_nx;
  logic [PLANE_W-1:0] plane_nx, plane_step;
  logic [CNT_W-1:0]   cnt, cnt_nx, dwell_load;
  logic               oe_nx, wrap_nx, frame_nx, plane_end;

  // Dwell lasts (prescale+1) * 2^plane cycles; the counter runs down to zero inclusive.
  assign dwell_load = ((CNT_W'(prescale) + CNT_W'(1)) << plane) - CNT_W'(1);

`ifdef BCM_REVERSE_PLANE_EN
  assign plane_end  = (plane == '0);
  assign plane_step = plane_end ? PLANE_LAST : plane - PLANE_W'(1);
`else
  assign plane_end  = (plane == PLANE_LAST);
  assign plane_step = plane_end ? '0 : plane + PLANE_W'(1);
`endif

  assign busy_dwell = (state == DWELL);

  always_comb begin
    state_nx   = state;
    address_nx = address;
    plane_nx   = plane;
    cnt_nx     = cnt;
    oe_nx      = 1'b0;
    wrap_nx    = 1'b0;
    frame_nx   = 1'b0;
    if (clr) begin
      state_nx   = SCAN;
      address_nx = '0;
      plane_nx   = PLANE_FIRST;
      cnt_nx     = '0;
    end else if (en) begin
      case (state)
        SCAN: begin
          if (address == ADDR_LAST) begin
            address_nx = '0;
            state_nx   = DWELL;
            cnt_nx     = dwell_load;
            wrap_nx    = 1'b1;
          end else begin
            address_nx = address + ADDR_W'(1);
          end
        end
        DWELL: begin
          if (cnt == '0) begin
            state_nx = SCAN;
            plane_nx = plane_step;
            frame_nx = plane_end;
          end else begin
            cnt_nx = cnt - CNT_W'(1);
          end
        end
        default: state_nx = SCAN;
      endcase
      // oe follows the registered state but only while advancing.
      oe_nx = (state_nx == DWELL);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SCAN;
      address    <= '0;
      plane      <= PLANE_FIRST;
      cnt        <= '0;
      oe         <= 1'b0;
      addr_wrap  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      address    <= address_nx;
      plane      <= plane_nx;
      cnt        <= cnt_nx;
      oe         <= oe_nx;
      addr_wrap  <= wrap_nx;
      frame_done <= frame_nx;
    end
  end

endmodule
